// File: rtl/cnn_sched_pkg.sv
// Shared sizes and scheduler state encoding for the CNN load scheduler.
package cnn_sched_pkg;
    localparam int DATA_W     = 8;
    localparam int IMG_PIXELS = 64;
    localparam int W_COUNT    = 54;
    localparam int AW         = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } sched_state_e;
endpackage

// File: rtl/pingpong_bank_tracker.sv
// Ping-pong image buffer bookkeeping: full flags, bank being filled, bank to consume next.
module pingpong_bank_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_set,
    input  logic       i_release,
    output logic [1:0] o_full,
    output logic       o_fill_bank,
    output logic       o_next_bank
);
    logic [1:0] r_full;
    logic       r_fill_bank;
    logic       r_next_bank;

    // set targets fill_bank (must be empty), release targets next_bank (must be full),
    // so both can land in the same cycle without touching the same flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full      <= 2'b00;
            r_fill_bank <= 1'b0;
            r_next_bank <= 1'b0;
        end else begin
            if (i_set) begin
                r_full[r_fill_bank] <= 1'b1;
                r_fill_bank         <= ~r_fill_bank;
            end
            if (i_release) begin
                r_full[r_next_bank] <= 1'b0;
                r_next_bank         <= ~r_next_bank;
            end
        end
    end

    assign o_full      = r_full;
    assign o_fill_bank = r_fill_bank;
    assign o_next_bank = r_next_bank;
endmodule

// File: rtl/cnn_load_sched.sv
// Byte-stream loader for weight RAM / ping-pong image buffer plus convolution-core scheduler.
// Define CNN_SCHED_PERF_EN to add the perf_img_cnt / perf_stall_cnt counters.
module cnn_load_sched
    import cnn_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [DATA_W-1:0] din,
    input  logic              ram_en,
    output logic              w_we,
    output logic [AW-1:0]     w_addr,
    output logic [DATA_W-1:0] w_wdata,
    output logic              d_we,
    output logic              d_bank,
    output logic [AW-1:0]     d_addr,
    output logic [DATA_W-1:0] d_wdata,
    output logic              calc_start,
    output logic              calc_bank,
    input  logic              calc_done,
    output logic              weight_ready,
    output logic              err_overrun
`ifdef CNN_SCHED_PERF_EN
    ,
    output logic [15:0]       perf_img_cnt,
    output logic [15:0]       perf_stall_cnt
`endif
);
    localparam logic [AW-1:0] W_LAST = AW'(W_COUNT - 1);
    localparam logic [AW-1:0] D_LAST = AW'(IMG_PIXELS - 1);

    sched_state_e  r_state, w_state_nxt;
    logic [AW-1:0] r_w_cnt, r_d_cnt;
    logic [1:0]    w_full;
    logic          w_fill_bank, w_next_bank;
    logic          w_w_req, w_d_req, w_w_acc, w_d_acc;
    logic          w_img_last, w_ready_set, w_release, w_calc_load;

    assign w_w_req    = ram_en & mode;
    assign w_d_req    = ram_en & ~mode;
    assign w_w_acc    = w_w_req & (r_state == IDLE) & (w_full == 2'b00) & (r_d_cnt == '0);
    assign w_d_acc    = w_d_req & ~w_full[w_fill_bank];
    assign w_img_last = w_d_acc & (r_d_cnt == D_LAST);
    assign w_release  = calc_done & (r_state == BUSY);
    // weight_ready follows the final weight write by one cycle
    assign w_ready_set = w_we & (w_addr == W_LAST);

    pingpong_bank_tracker u_banks (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_set       (w_img_last),
        .i_release   (w_release),
        .o_full      (w_full),
        .o_fill_bank (w_fill_bank),
        .o_next_bank (w_next_bank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_cnt      <= '0;
            r_d_cnt      <= '0;
            weight_ready <= 1'b0;
            err_overrun  <= 1'b0;
            w_we         <= 1'b0;
            w_addr       <= '0;
            w_wdata      <= '0;
            d_we         <= 1'b0;
            d_bank       <= 1'b0;
            d_addr       <= '0;
            d_wdata      <= '0;
        end else begin
            w_we <= w_w_acc;
            d_we <= w_d_acc;
            // w_cnt is already 0 whenever a reload begins, so the reload byte lands at 0
            if (w_w_acc) begin
                w_addr  <= r_w_cnt;
                w_wdata <= din;
                r_w_cnt <= (r_w_cnt == W_LAST) ? '0 : r_w_cnt + 1'b1;
            end
            if (w_w_acc)
                weight_ready <= 1'b0;
            else if (w_ready_set)
                weight_ready <= 1'b1;
            if (w_d_acc) begin
                d_bank  <= w_fill_bank;
                d_addr  <= r_d_cnt;
                d_wdata <= din;
                r_d_cnt <= (r_d_cnt == D_LAST) ? '0 : r_d_cnt + 1'b1;
            end
            if ((w_w_req & ~w_w_acc) | (w_d_req & ~w_d_acc))
                err_overrun <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_calc_load = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (weight_ready && w_full[w_next_bank]) begin
                    w_state_nxt = START;
                    w_calc_load = 1'b1;
                end
            end
            START:   w_state_nxt = BUSY;
            BUSY:    if (calc_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // calc_start is registered off START so it trails the last pixel write by two cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            calc_bank  <= 1'b0;
            calc_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            calc_start <= (r_state == START);
            if (w_calc_load)
                calc_bank <= w_next_bank;
        end
    end

`ifdef CNN_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_img_cnt   <= 16'd0;
            perf_stall_cnt <= 16'd0;
        end else begin
            if (w_release)
                perf_img_cnt <= perf_img_cnt + 16'd1;
            if (w_full[w_next_bank] && (r_state != IDLE) && (perf_stall_cnt != 16'hFFFF))
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cnn_load_sched.sv
// Scoreboard bench for cnn_load_sched: expected RAM writes queued at drive time, popped on *_we.
module tb_cnn_load_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ram_en = 1'b0;
    logic       calc_done = 1'b0;
    logic       w_we, d_we, d_bank, calc_start, calc_bank, weight_ready, err_overrun;
    logic [5:0] w_addr, d_addr;
    logic [7:0] w_wdata, d_wdata;
`ifdef CNN_SCHED_PERF_EN
    logic [15:0] perf_img_cnt, perf_stall_cnt;
`endif

    cnn_load_sched dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .din(din), .ram_en(ram_en),
        .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata),
        .d_we(d_we), .d_bank(d_bank), .d_addr(d_addr), .d_wdata(d_wdata),
        .calc_start(calc_start), .calc_bank(calc_bank), .calc_done(calc_done),
        .weight_ready(weight_ready), .err_overrun(err_overrun)
`ifdef CNN_SCHED_PERF_EN
        , .perf_img_cnt(perf_img_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_w;
        logic       bank;
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   start_cyc = 0;
    logic start_bank = 1'b0;
    int   last_d_cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    // write monitor / scoreboard and calc_start recorder
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_we || d_we) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got w_we=%0b d_we=%0b bank=%0d w_addr=%0d d_addr=%0d, expected no write",
                             w_we, d_we, d_bank, w_addr, d_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_w) begin
                        if (!(w_we === 1'b1 && d_we === 1'b0 && w_addr === mon_e.addr && w_wdata === mon_e.data)) begin
                            n_fail++;
                            $display("FAIL weight_write: got w_we=%0b d_we=%0b addr=%0d data=%h, expected weight addr=%0d data=%h",
                                     w_we, d_we, w_addr, w_wdata, mon_e.addr, mon_e.data);
                        end
                    end else begin
                        if (!(d_we === 1'b1 && w_we === 1'b0 && d_bank === mon_e.bank &&
                              d_addr === mon_e.addr && d_wdata === mon_e.data)) begin
                            n_fail++;
                            $display("FAIL image_write: got d_we=%0b w_we=%0b bank=%0d addr=%0d data=%h, expected bank=%0d addr=%0d data=%h",
                                     d_we, w_we, d_bank, d_addr, d_wdata, mon_e.bank, mon_e.addr, mon_e.data);
                        end
                    end
                end
            end
            if (d_we) last_d_cyc = cyc;
            if (calc_start) begin
                start_cnt++;
                start_cyc  = cyc;
                start_bank = calc_bank;
            end
        end
    end

    task automatic drive(input logic m, input logic [7:0] d, input logic accept,
                         input logic bank, input logic [5:0] addr);
        wr_t e;
        @(negedge clk);
        mode = m; din = d; ram_en = 1'b1;
        if (accept) begin
            e.is_w = m; e.bank = m ? 1'b0 : bank; e.addr = addr; e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ram_en = 1'b0;
        end
    endtask

    task automatic load_weights;
        for (int i = 0; i < 54; i++) drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 6'(i));
    endtask

    task automatic wait_start(input int prev, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (start_cnt > prev) break;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; ram_en = 1'b0; calc_done = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({w_we, w_addr, w_wdata} !== 15'd0) begin
            n_fail++; $display("FAIL reset_wport: got %h, expected 0", {w_we, w_addr, w_wdata});
        end
        n_checks++;
        if ({d_we, d_bank, d_addr, d_wdata} !== 16'd0) begin
            n_fail++; $display("FAIL reset_dport: got %h, expected 0", {d_we, d_bank, d_addr, d_wdata});
        end
        n_checks++;
        if ({calc_start, calc_bank, weight_ready, err_overrun} !== 4'd0) begin
            n_fail++; $display("FAIL reset_status: got %b, expected 0000", {calc_start, calc_bank, weight_ready, err_overrun});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_weight_load;
        load_weights();
        @(negedge clk); ram_en = 1'b0;
        n_checks++;
        if (!(w_we === 1'b1 && w_addr === 6'd53 && weight_ready === 1'b0)) begin
            n_fail++; $display("FAIL wready_early: got w_we=%0b addr=%0d ready=%0b, expected 1/53/0", w_we, w_addr, weight_ready);
        end
        @(negedge clk);
        n_checks++;
        if (weight_ready !== 1'b1) begin
            n_fail++; $display("FAIL wready_rise: got %0b, expected 1", weight_ready);
        end
        idle(4);
        @(posedge clk);
        n_checks++;
        if (start_cnt !== 0) begin
            n_fail++; $display("FAIL weights_no_start: got %0d starts, expected 0", start_cnt);
        end
    endtask

    task automatic test_single_image;
        int prev = start_cnt;
        for (int i = 0; i < 64; i++) begin
            idle(int'($urandom_range(0, 2)));
            drive(1'b0, 8'(i * 3 + 1), 1'b1, 1'b0, 6'(i));
        end
        idle(1);
        wait_start(prev, 20);
        n_checks++;
        if (start_cnt !== prev + 1) begin
            n_fail++; $display("FAIL img0_start_count: got %0d, expected %0d", start_cnt, prev + 1);
        end else begin
            n_checks++;
            if (start_cyc - last_d_cyc !== 2) begin
                n_fail++; $display("FAIL img0_start_latency: got %0d, expected 2", start_cyc - last_d_cyc);
            end
            n_checks++;
            if (start_bank !== 1'b0) begin
                n_fail++; $display("FAIL img0_calc_bank: got %0b, expected 0", start_bank);
            end
        end
    endtask

    task automatic test_ping_pong;
        int prev = start_cnt;
        int done_cyc;
        for (int i = 0; i < 64; i++) drive(1'b0, 8'(8'hA0 ^ i), 1'b1, 1'b1, 6'(i));
        idle(4);
        @(posedge clk);
        n_checks++;
        if (start_cnt !== prev || calc_bank !== 1'b0) begin
            n_fail++; $display("FAIL busy_hold: got starts=%0d calc_bank=%0b, expected %0d/0", start_cnt, calc_bank, prev);
        end
        @(negedge clk); calc_done = 1'b1; done_cyc = cyc + 1;
        @(negedge clk); calc_done = 1'b0;
        wait_start(prev, 10);
        n_checks++;
        if (start_cnt !== prev + 1 || start_cyc !== done_cyc + 2) begin
            n_fail++; $display("FAIL pp_start: got starts=%0d at cyc %0d, expected %0d at cyc %0d", start_cnt, start_cyc, prev + 1, done_cyc + 2);
        end
        n_checks++;
        if (start_bank !== 1'b1) begin
            n_fail++; $display("FAIL pp_calc_bank: got %0b, expected 1", start_bank);
        end
        n_checks++;
        if (err_overrun !== 1'b0) begin
            n_fail++; $display("FAIL pp_no_overrun: got %0b, expected 0", err_overrun);
        end
    endtask

    task automatic test_overrun;
        int prev = start_cnt;
        int done_cyc;
        for (int i = 0; i < 64; i++) drive(1'b0, 8'(i), 1'b1, 1'b0, 6'(i));
        drive(1'b0, 8'hEE, 1'b0, 1'b0, 6'd0);
        idle(2);
        n_checks++;
        if (err_overrun !== 1'b1) begin
            n_fail++; $display("FAIL overrun_set: got %0b, expected 1", err_overrun);
        end
        idle(5);
        @(posedge clk);
        n_checks++;
        if (err_overrun !== 1'b1 || start_cnt !== prev) begin
            n_fail++; $display("FAIL overrun_sticky: got err=%0b starts=%0d, expected 1/%0d", err_overrun, start_cnt, prev);
        end
        // byte on the release edge still sees the bank full; the next one is accepted
        @(negedge clk);
        calc_done = 1'b1; mode = 1'b0; din = 8'h5A; ram_en = 1'b1; done_cyc = cyc + 1;
        drive(1'b0, 8'hC3, 1'b1, 1'b1, 6'd0);
        calc_done = 1'b0;
        idle(1);
        wait_start(prev, 10);
        n_checks++;
        if (start_cnt !== prev + 1 || start_cyc !== done_cyc + 2 || start_bank !== 1'b0) begin
            n_fail++; $display("FAIL release_restart: got starts=%0d cyc=%0d bank=%0b, expected %0d/%0d/0",
                               start_cnt, start_cyc, start_bank, prev + 1, done_cyc + 2);
        end
    endtask

    task automatic test_illegal_reload;
        load_weights();
        idle(3);
        for (int i = 0; i < 10; i++) drive(1'b0, 8'(8'h20 + i), 1'b1, 1'b0, 6'(i));
        drive(1'b1, 8'h77, 1'b0, 1'b0, 6'd0);
        drive(1'b0, 8'h10, 1'b1, 1'b0, 6'd10);
        idle(2);
        n_checks++;
        if (err_overrun !== 1'b1) begin
            n_fail++; $display("FAIL reload_err: got %0b, expected 1", err_overrun);
        end
        n_checks++;
        if (weight_ready !== 1'b1) begin
            n_fail++; $display("FAIL reload_wready: got %0b, expected 1", weight_ready);
        end
    endtask

    task automatic test_reset_mid_image;
        int prev;
        load_weights();
        idle(3);
        for (int i = 0; i < 30; i++) drive(1'b0, 8'(8'h90 + i), 1'b1, 1'b0, 6'(i));
        drive(1'b0, 8'hFF, 1'b0, 1'b0, 6'd0);
        @(posedge clk);
        #2 rst_n = 1'b0; ram_en = 1'b0;
        #1;
        n_checks++;
        if ({d_we, d_bank, d_addr, d_wdata, weight_ready, calc_start, calc_bank, err_overrun} !== 20'd0) begin
            n_fail++; $display("FAIL async_reset: got d_we=%0b addr=%0d ready=%0b err=%0b, expected all 0",
                               d_we, d_addr, weight_ready, err_overrun);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        prev = start_cnt;
        for (int i = 0; i < 64; i++) drive(1'b0, 8'(8'h11 * i), 1'b1, 1'b0, 6'(i));
        idle(6);
        @(posedge clk);
        n_checks++;
        if (start_cnt !== prev) begin
            n_fail++; $display("FAIL reset_drops_weights: got %0d starts, expected %0d", start_cnt, prev);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_weight_load();
        test_single_image();
        test_ping_pong();
        test_overrun();
        test_reset();
        test_illegal_reload();
        test_reset();
        test_reset_mid_image();
        idle(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL missing_writes: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
